// File: rtl/conv3x3_sched.sv
// 3x3 convolution sequencer: holds kernel weights, walks the image in raster order,
// fetches each window from a sync-read pixel memory and streams MAC results.
module conv3x3_sched #(
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int ADDR_W = 6,
    parameter int RELU   = 0
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic                     wt_we_i,
    input  logic [3:0]               wt_idx_i,
    input  logic signed [7:0]        wt_data_i,
    output logic                     mem_re_o,
    output logic [ADDR_W-1:0]        mem_addr_o,
    input  logic [7:0]               mem_rdata_i,
    output logic [7:0]               px0_o,
    output logic [7:0]               px1_o,
    output logic [7:0]               px2_o,
    output logic [7:0]               px3_o,
    output logic [7:0]               px4_o,
    output logic [7:0]               px5_o,
    output logic [7:0]               px6_o,
    output logic [7:0]               px7_o,
    output logic [7:0]               px8_o,
    output logic signed [7:0]        wt0_o,
    output logic signed [7:0]        wt1_o,
    output logic signed [7:0]        wt2_o,
    output logic signed [7:0]        wt3_o,
    output logic signed [7:0]        wt4_o,
    output logic signed [7:0]        wt5_o,
    output logic signed [7:0]        wt6_o,
    output logic signed [7:0]        wt7_o,
    output logic signed [7:0]        wt8_o,
    input  logic signed [31:0]       mac_out_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic signed [31:0]       out_data_o,
    output logic                     out_last_o,
    output logic                     busy_o,
    output logic                     done_o
);

    // state | meaning
    // IDLE  | weights writable, waiting for start
    // FETCH | k=0..8 issue window reads, k=1..9 capture returning pixels
    // CALC  | register the MAC result for the current window
    // OUT   | hold result until downstream accepts it
    // DONE  | one-cycle done pulse, then back to IDLE

    localparam int RW = $clog2(IMG_H);
    localparam int CW = $clog2(IMG_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CALC,
        S_OUT,
        S_DONE
    } state_t;

    state_t                  state_q;
    logic [RW-1:0]           row_q;
    logic [CW-1:0]           col_q;
    logic [3:0]              k_q;
    logic                    mem_re_q;
    logic [ADDR_W-1:0]       mem_addr_q;
    logic [7:0]              px_q [9];
    logic signed [7:0]       wt_q [9];
    logic                    out_valid_q;
    logic signed [31:0]      out_data_q;
    logic                    out_last_q;
    logic                    busy_q;
    logic                    done_q;

    logic [RW-1:0]           row_d;
    logic [CW-1:0]           col_d;
    logic                    col_wrap;
    logic                    last_win;

    function automatic logic [ADDR_W-1:0] win_addr(
        input logic [RW-1:0] r,
        input logic [CW-1:0] c,
        input logic [3:0]    k
    );
        int rr;
        int cc;
        rr = int'(r) + int'(k) / 3;
        cc = int'(c) + int'(k) % 3;
        return ADDR_W'(rr * IMG_W + cc);
    endfunction

    // Position of the window that follows the current one in raster order.
    always_comb begin
        col_wrap = (col_q == CW'(IMG_W - 3));
        last_win = (row_q == RW'(IMG_H - 3)) && col_wrap;
        row_d    = row_q;
        col_d    = col_q + CW'(1);
        if (col_wrap) begin
            col_d = '0;
            row_d = row_q + RW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            row_q       <= '0;
            col_q       <= '0;
            k_q         <= '0;
            mem_re_q    <= 1'b0;
            mem_addr_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                px_q[i] <= '0;
                wt_q[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (wt_we_i) begin
                        for (int i = 0; i < 9; i++) begin
                            if (wt_idx_i == 4'(i)) begin
                                wt_q[i] <= wt_data_i;
                            end
                        end
                    end
                    if (start_i) begin
                        row_q      <= '0;
                        col_q      <= '0;
                        k_q        <= '0;
                        mem_re_q   <= 1'b1;
                        mem_addr_q <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= S_FETCH;
                    end
                end

                S_FETCH: begin
                    // Data for the read issued at k-1 is on mem_rdata_i during k.
                    for (int i = 0; i < 9; i++) begin
                        if (k_q == 4'(i + 1)) begin
                            px_q[i] <= mem_rdata_i;
                        end
                    end
                    if (k_q == 4'd9) begin
                        k_q     <= '0;
                        state_q <= S_CALC;
                    end else begin
                        k_q <= k_q + 4'd1;
                        if (k_q < 4'd8) begin
                            mem_re_q   <= 1'b1;
                            mem_addr_q <= win_addr(row_q, col_q, k_q + 4'd1);
                        end else begin
                            mem_re_q <= 1'b0;
                        end
                    end
                end

                S_CALC: begin
                    if ((RELU != 0) && mac_out_i[31]) begin
                        out_data_q <= '0;
                    end else begin
                        out_data_q <= mac_out_i;
                    end
                    out_valid_q <= 1'b1;
                    out_last_q  <= last_win;
                    state_q     <= S_OUT;
                end

                S_OUT: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        if (out_last_q) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            row_q      <= row_d;
                            col_q      <= col_d;
                            k_q        <= '0;
                            mem_re_q   <= 1'b1;
                            mem_addr_q <= win_addr(row_d, col_d, 4'd0);
                            state_q    <= S_FETCH;
                        end
                    end
                end

                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end

                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_re_o    = mem_re_q;
    assign mem_addr_o  = mem_addr_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_last_o  = out_last_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

    assign px0_o = px_q[0];
    assign px1_o = px_q[1];
    assign px2_o = px_q[2];
    assign px3_o = px_q[3];
    assign px4_o = px_q[4];
    assign px5_o = px_q[5];
    assign px6_o = px_q[6];
    assign px7_o = px_q[7];
    assign px8_o = px_q[8];

    assign wt0_o = wt_q[0];
    assign wt1_o = wt_q[1];
    assign wt2_o = wt_q[2];
    assign wt3_o = wt_q[3];
    assign wt4_o = wt_q[4];
    assign wt5_o = wt_q[5];
    assign wt6_o = wt_q[6];
    assign wt7_o = wt_q[7];
    assign wt8_o = wt_q[8];

endmodule

// File: tb/tb_conv3x3_sched.sv
// Bench for conv3x3_sched: two instances (RELU=0 / RELU=1) share stimulus,
// each with its own sync-read pixel memory port and reference MAC.
module tb_conv3x3_sched;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic                wt_we;
    logic [3:0]          wt_idx;
    logic signed [7:0]   wt_data;
    logic                out_ready;

    logic                mem_re_a, mem_re_b;
    logic [5:0]          mem_addr_a, mem_addr_b;
    logic [7:0]          rdata_a, rdata_b;
    logic [7:0]          pxa [9];
    logic [7:0]          pxb [9];
    logic signed [7:0]   wta [9];
    logic signed [7:0]   wtb [9];
    logic signed [31:0]  mac_a, mac_b;
    logic                out_valid_a, out_valid_b;
    logic signed [31:0]  out_data_a, out_data_b;
    logic                out_last_a, out_last_b;
    logic                busy_a, busy_b;
    logic                done_a, done_b;

    logic [7:0]          mem [64];
    int                  cyc = 0;
    int                  done_cnt = 0;
    int                  checks = 0;
    int                  errors = 0;
    int                  exp_addr [9] = '{0, 1, 2, 8, 9, 10, 16, 17, 18};

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (done_a) done_cnt <= done_cnt + 1;

    always @(posedge clk) if (mem_re_a) rdata_a <= mem[mem_addr_a];
    always @(posedge clk) if (mem_re_b) rdata_b <= mem[mem_addr_b];

    function automatic logic signed [31:0] mac9(input logic [7:0] p [9], input logic signed [7:0] w [9]);
        int s;
        s = 0;
        for (int i = 0; i < 9; i++) s += int'(p[i]) * int'(w[i]);
        return s;
    endfunction

    assign mac_a = mac9(pxa, wta);
    assign mac_b = mac9(pxb, wtb);

    conv3x3_sched #(.IMG_W(8), .IMG_H(8), .ADDR_W(6), .RELU(0)) dut_a (
        .clk_i(clk), .rst_i(rst), .start_i(start), .wt_we_i(wt_we), .wt_idx_i(wt_idx), .wt_data_i(wt_data),
        .mem_re_o(mem_re_a), .mem_addr_o(mem_addr_a), .mem_rdata_i(rdata_a),
        .px0_o(pxa[0]), .px1_o(pxa[1]), .px2_o(pxa[2]), .px3_o(pxa[3]), .px4_o(pxa[4]),
        .px5_o(pxa[5]), .px6_o(pxa[6]), .px7_o(pxa[7]), .px8_o(pxa[8]),
        .wt0_o(wta[0]), .wt1_o(wta[1]), .wt2_o(wta[2]), .wt3_o(wta[3]), .wt4_o(wta[4]),
        .wt5_o(wta[5]), .wt6_o(wta[6]), .wt7_o(wta[7]), .wt8_o(wta[8]),
        .mac_out_i(mac_a), .out_valid_o(out_valid_a), .out_ready_i(out_ready),
        .out_data_o(out_data_a), .out_last_o(out_last_a), .busy_o(busy_a), .done_o(done_a)
    );

    conv3x3_sched #(.IMG_W(8), .IMG_H(8), .ADDR_W(6), .RELU(1)) dut_b (
        .clk_i(clk), .rst_i(rst), .start_i(start), .wt_we_i(wt_we), .wt_idx_i(wt_idx), .wt_data_i(wt_data),
        .mem_re_o(mem_re_b), .mem_addr_o(mem_addr_b), .mem_rdata_i(rdata_b),
        .px0_o(pxb[0]), .px1_o(pxb[1]), .px2_o(pxb[2]), .px3_o(pxb[3]), .px4_o(pxb[4]),
        .px5_o(pxb[5]), .px6_o(pxb[6]), .px7_o(pxb[7]), .px8_o(pxb[8]),
        .wt0_o(wtb[0]), .wt1_o(wtb[1]), .wt2_o(wtb[2]), .wt3_o(wtb[3]), .wt4_o(wtb[4]),
        .wt5_o(wtb[5]), .wt6_o(wtb[6]), .wt7_o(wtb[7]), .wt8_o(wtb[8]),
        .mac_out_i(mac_b), .out_valid_o(out_valid_b), .out_ready_i(out_ready),
        .out_data_o(out_data_b), .out_last_o(out_last_b), .busy_o(busy_b), .done_o(done_b)
    );

    task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int wsum();
        int s;
        s = 0;
        for (int i = 0; i < 9; i++) s += int'(wta[i]);
        return s;
    endfunction

    function automatic int nz_count();
        int n;
        n = 0;
        for (int i = 0; i < 9; i++) begin
            if (pxa[i] != 0) n++;
            if (wta[i] != 0) n++;
        end
        return n;
    endfunction

    // Hand-derived results for an 8x8 image with 6x6 output windows.
    function automatic int exp_res(input int wmode, input int r, input int c);
        case (wmode)
            0:       return 81 + 72 * r + 9 * c;
            1:       return (r + 1) * 8 + c + 1;
            default: return -293760;
        endcase
    endfunction

    function automatic int relu(input int v);
        return (v < 0) ? 0 : v;
    endfunction

    task automatic wr_wt(input int idx, input int data);
        @(negedge clk);
        wt_we   = 1'b1;
        wt_idx  = 4'(idx);
        wt_data = 8'(data);
        @(negedge clk);
        wt_we   = 1'b0;
    endtask

    task automatic load_weights(input int wmode);
        for (int i = 0; i < 9; i++) begin
            case (wmode)
                0:       wr_wt(i, 1);
                1:       wr_wt(i, (i == 4) ? 1 : 0);
                default: wr_wt(i, -128);
            endcase
        end
    endtask

    task automatic set_pix(input int wmode);
        for (int i = 0; i < 64; i++) mem[i] = (wmode == 2) ? 8'd255 : 8'(i);
    endtask

    task automatic run_frame(input int wmode, input int stall_idx, input bit poke,
                             input int exp_first, input int exp_last);
        int n, guard, start_c, last_hs, stall_cnt, d0, exp_v;
        bit seen_v, poked;
        logic [5:0] addrs [$];
        n = 0; guard = 0; stall_cnt = 0; last_hs = 0; seen_v = 0; poked = 0;
        d0 = done_cnt;
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        start_c = cyc;
        chk("busy_after_start", busy_a, 1);
        chk("mem_re_after_start", mem_re_a, 1);
        while (n < 36 && guard < 3000) begin
            if (n == 0 && mem_re_a) addrs.push_back(mem_addr_a);
            if (!seen_v && out_valid_a) begin
                seen_v = 1;
                chk("first_valid_latency", cyc - start_c, 11);
            end
            start = 1'b0;
            wt_we = 1'b0;
            if (poke && n == 10 && !poked) begin
                poked   = 1;
                start   = 1'b1;
                wt_we   = 1'b1;
                wt_idx  = 4'd0;
                wt_data = 8'sd100;
            end
            if (out_valid_a && n == stall_idx && stall_cnt < 5) begin
                out_ready = 1'b0;
                stall_cnt++;
                chk("stall_no_read", mem_re_a, 0);
                chk("stall_hold_data", out_data_a, exp_res(wmode, n / 6, n % 6));
            end else begin
                out_ready = 1'b1;
            end
            if (out_valid_a && out_ready) begin
                exp_v = exp_res(wmode, n / 6, n % 6);
                chk("result", out_data_a, exp_v);
                chk("result_relu", out_data_b, relu(exp_v));
                chk("out_last", out_last_a, (n == 35));
                if (n == 0) chk("first_result", out_data_a, exp_first);
                if (n == 35) chk("last_result", out_data_a, exp_last);
                if (n > 0) chk("result_spacing", cyc - last_hs, (n == stall_idx) ? 17 : 12);
                last_hs = cyc;
                n++;
            end
            @(negedge clk);
            guard++;
        end
        start = 1'b0;
        wt_we = 1'b0;
        out_ready = 1'b1;
        chk("result_count", n, 36);
        chk("done_pulse", done_a, 1);
        chk("busy_in_done", busy_a, 1);
        chk("valid_dropped", out_valid_a, 0);
        @(negedge clk);
        chk("done_low", done_a, 0);
        chk("busy_low", busy_a, 0);
        chk("done_once", done_cnt - d0, 1);
        if (wmode == 1) begin
            chk("addr_count", addrs.size(), 9);
            for (int i = 0; i < 9 && i < addrs.size(); i++) chk("first_window_addr", addrs[i], exp_addr[i]);
        end
        if (poke) chk("busy_wt_write_ignored", wta[0], 1);
    endtask

    typedef struct {
        logic [3:0]        idx;
        logic signed [7:0] data;
        int                exp_sum;
    } wvec_t;

    typedef struct {
        int wmode;
        int stall_idx;
        bit poke;
        int exp_first;
        int exp_last;
    } fvec_t;

    wvec_t wtab [10];
    fvec_t ftab [4];

    initial begin
        wtab[0] = '{4'd0, 8'sd1, 1};
        wtab[1] = '{4'd1, 8'sd2, 3};
        wtab[2] = '{4'd2, 8'sd3, 6};
        wtab[3] = '{4'd3, 8'sd4, 10};
        wtab[4] = '{4'd4, 8'sd5, 15};
        wtab[5] = '{4'd5, 8'sd6, 21};
        wtab[6] = '{4'd6, 8'sd7, 28};
        wtab[7] = '{4'd7, 8'sd8, 36};
        wtab[8] = '{4'd8, 8'sd9, 45};
        wtab[9] = '{4'd12, 8'sd77, 45};

        ftab[0] = '{0, -1, 1'b1, 81, 486};
        ftab[1] = '{1, -1, 1'b0, 9, 54};
        ftab[2] = '{2, -1, 1'b0, -293760, -293760};
        ftab[3] = '{0, 3, 1'b0, 81, 486};

        rst = 1'b1; start = 1'b0; wt_we = 1'b0; wt_idx = '0; wt_data = '0; out_ready = 1'b0;
        for (int i = 0; i < 64; i++) mem[i] = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy_a, 0);
        chk("rst_mem_re", mem_re_a, 0);
        chk("rst_mem_addr", mem_addr_a, 0);
        chk("rst_out_valid", out_valid_a, 0);
        chk("rst_out_data", out_data_a, 0);
        chk("rst_regs", nz_count(), 0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            wr_wt(int'(wtab[i].idx), int'(wtab[i].data));
            chk("wt_sum", wsum(), wtab[i].exp_sum);
        end
        for (int i = 0; i < 9; i++) chk("wt_value", wta[i], i + 1);
        chk("wt_no_activity", busy_a | mem_re_a | out_valid_a, 0);

        for (int f = 0; f < 4; f++) begin
            load_weights(ftab[f].wmode);
            set_pix(ftab[f].wmode);
            run_frame(ftab[f].wmode, ftab[f].stall_idx, ftab[f].poke, ftab[f].exp_first, ftab[f].exp_last);
        end

        // Abort mid-FETCH of the second window, then restart cleanly.
        load_weights(0);
        set_pix(0);
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (15) @(negedge clk);
        chk("pre_reset_fetching", mem_re_a, 1);
        chk("pre_reset_result", out_data_a, 81);
        begin
            int d0;
            d0 = done_cnt;
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            chk("abort_busy", busy_a, 0);
            chk("abort_mem_re", mem_re_a, 0);
            chk("abort_mem_addr", mem_addr_a, 0);
            chk("abort_out_valid", out_valid_a, 0);
            chk("abort_out_last", out_last_a, 0);
            chk("abort_out_data", out_data_a, 0);
            chk("abort_done", done_a, 0);
            chk("abort_regs", nz_count(), 0);
            repeat (20) @(negedge clk);
            chk("abort_no_done", done_cnt - d0, 0);
            chk("abort_stays_idle", busy_a, 0);
        end
        load_weights(0);
        run_frame(0, -1, 1'b0, 81, 486);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
